// File: rtl/toggle_meter_pkg.sv
// Shared types for the toggle period meter and its helpers.
//   meter_state_e : measurement FSM states
//   CntWDefault   : default period counter width
//   SyncStagesDefault : default synchronizer depth
//   meas_t        : packed measurement record {period, rise, ovf} at default width
package toggle_meter_pkg;

   localparam int unsigned CntWDefault       = 16;
   localparam int unsigned SyncStagesDefault = 2;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StMeasure
   } meter_state_e;

   typedef struct packed {
      logic [CntWDefault-1:0] period;
      logic                   rise;
      logic                   ovf;
   } meas_t;

endpackage

// File: rtl/toggle_period_meter_if.sv
// Measurement output channel of the toggle period meter (valid/ready).
//   master : producer (the meter) drives valid and data, samples ready
//   slave  : consumer drives ready, samples valid and data
interface toggle_period_meter_if import toggle_meter_pkg::*; #(
   parameter int unsigned CNT_W = CntWDefault
);

   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] meas_period;
   logic             meas_rise;
   logic             meas_ovf;

   modport master (
      output meas_valid,
      output meas_period,
      output meas_rise,
      output meas_ovf,
      input  meas_ready
   );

   modport slave (
      input  meas_valid,
      input  meas_period,
      input  meas_rise,
      input  meas_ovf,
      output meas_ready
   );

endinterface

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous line and flags level changes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   async_in    : asynchronous input line
//   clr         : masks edge_pulse (history keeps tracking so no stale edge on release)
//   edge_pulse  : synchronized value differs from history value
//   edge_rise   : new synchronized level (1 = 0->1 edge)
module sync_edge_detect import toggle_meter_pkg::*; #(
   parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   input  logic clr,
   output logic edge_pulse,
   output logic edge_rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_pulse = ~clr & (sync_q[SYNC_STAGES-1] ^ hist_q);
   assign edge_rise  = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_period_meter.sv
// Measures clk cycles between consecutive edges of an asynchronous toggle line.
//   clk, rst_n : clock, asynchronous active-low reset
//   toggle_in  : asynchronous toggle line
//   enable     : low forces IDLE (counter/ovf cleared, pending output kept)
//   meas       : one-deep valid/ready output {period, rise, ovf}
//   dropped    : sticky, a capture was discarded because the output was full
module toggle_period_meter import toggle_meter_pkg::*; #(
   parameter int unsigned CNT_W       = CntWDefault,
   parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         toggle_in,
   input  logic                         enable,
   toggle_period_meter_if.master        meas,
   output logic                         dropped
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   meter_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;

   logic             sync_clr;
   logic             edge_pulse;
   logic             edge_rise;
   logic             capture;

   logic             valid_q;
   logic [CNT_W-1:0] period_q;
   logic             rise_q;
   logic             movf_q;
   logic             dropped_q;

   assign sync_clr = (state_q == StIdle);

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_in  (toggle_in),
      .clr       (sync_clr),
      .edge_pulse(edge_pulse),
      .edge_rise (edge_rise)
   );

   // Enable low wins over a coincident edge.
   assign capture = enable & edge_pulse & (state_q == StMeasure);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (!enable) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= StArmed;
            StArmed: begin
               if (edge_pulse) begin
                  state_q <= StMeasure;
                  cnt_q   <= CNT_W'(1);
               end
            end
            StMeasure: begin
               if (edge_pulse) begin
                  cnt_q <= CNT_W'(1);
                  ovf_q <= 1'b0;
               end else if (cnt_q == CntMax) begin
                  // Another cycle passed at full count: true period exceeds CntMax.
                  ovf_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         period_q  <= '0;
         rise_q    <= 1'b0;
         movf_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else if (capture && (!valid_q || meas.meas_ready)) begin
         valid_q  <= 1'b1;
         period_q <= cnt_q;
         rise_q   <= edge_rise;
         movf_q   <= ovf_q;
      end else begin
         if (capture) begin
            dropped_q <= 1'b1;
         end
         if (valid_q && meas.meas_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign meas.meas_valid  = valid_q;
   assign meas.meas_period = period_q;
   assign meas.meas_rise   = rise_q;
   assign meas.meas_ovf    = movf_q;
   assign dropped          = dropped_q;

endmodule
